display_scan_controller: RTL and testbench

//  Time-multiplexes NUM_DIGITS 4-bit codes onto one shared 15-segment alphanumeric decoder.

---
 rtl/display_scan_controller_pkg.sv | 17 +
 rtl/display_scan_controller_if.sv | 14 +
 rtl/display_scan_controller_scan_timer.sv | 26 ++
 rtl/display_scan_controller.sv | 148 ++++++++++++++
 tb/tb_display_scan_controller.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_controller_pkg.sv
// Shared state encodings, field widths and sizing helper for the display scan controller.
package display_scan_controller_pkg;

  localparam int CODE_W = 4;
  localparam int SEG_W  = 15;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // Counter width able to hold 0..max_count-1; never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Frame-load handshake between the host (master) and the scan controller (slave).
interface display_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  import display_scan_controller_pkg::*;

  logic                         load_valid;
  logic                         load_ready;
  logic [CODE_W*NUM_DIGITS-1:0] load_data;

  modport master (output load_valid, output load_data, input  load_ready);
  modport slave  (input  load_valid, input  load_data, output load_ready);

endinterface

// File: rtl/display_scan_controller_scan_timer.sv
// Clearable up-counter; tc flags that the count has reached the supplied limit.
module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb count_d = clr ? '0 : count_q + 1'b1;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign tc = (count_q == limit);

endmodule

// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS codes through one external 15-segment decoder with a dark gap per digit.
// Optional LEADING_ZERO_BLANK_EN suppresses the drive of leading zero digits.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       scan_en,
  display_scan_controller_if.slave   load_if,
  output logic [CODE_W-1:0]          digit_code,
  input  logic [SEG_W-1:0]           segment_in,
  output logic [SEG_W-1:0]           segment_out,
  output logic [NUM_DIGITS-1:0]      digit_enable,
  output logic                       frame_done
);

  localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW   = cnt_width(TMAX);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int DW   = CODE_W * NUM_DIGITS;

  localparam logic [TW-1:0] BLANK_LIM = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LIM = TW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  state_e                state_q,        state_d;
  logic [IW-1:0]         index_q,        index_d;
  logic [DW-1:0]         shadow_q,       shadow_d;
  logic [DW-1:0]         pending_q,      pending_d;
  logic                  load_ready_q,   load_ready_d;
  logic [SEG_W-1:0]      segment_out_q,  segment_out_d;
  logic [NUM_DIGITS-1:0] digit_enable_q, digit_enable_d;
  logic                  frame_done_q,   frame_done_d;

  logic          timer_clr;
  logic          timer_tc;
  logic [TW-1:0] timer_limit;
  logic          digit_lit;

  assign timer_limit = (state_q == ST_BLANK) ? BLANK_LIM : DWELL_LIM;

  scan_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .limit (timer_limit),
    .tc    (timer_tc)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Lit when this digit or any more significant digit is non-zero; digit 0 always lit.
  always_comb begin
    digit_lit = (index_q == '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(index_q) && shadow_q[i*CODE_W +: CODE_W] != '0) digit_lit = 1'b1;
    end
  end
`else
  assign digit_lit = 1'b1;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d        = state_q;
    index_d        = index_q;
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    load_ready_d   = load_ready_q;
    segment_out_d  = segment_out_q;
    digit_enable_d = digit_enable_q;
    frame_done_d   = 1'b0;
    timer_clr      = 1'b0;

    unique case (state_q)
      ST_BLANK: begin
        if (!scan_en) begin
          timer_clr = 1'b1;
        end else if (timer_tc) begin
          state_d        = ST_SHOW;
          timer_clr      = 1'b1;
          segment_out_d  = segment_in;
          digit_enable_d = digit_lit ? (NUM_DIGITS'(1) << index_q) : '0;
        end
      end
      ST_SHOW: begin
        if (timer_tc) begin
          state_d        = ST_BLANK;
          timer_clr      = 1'b1;
          segment_out_d  = '0;
          digit_enable_d = '0;
          if (index_q == LAST_IDX) begin
            index_d      = '0;
            frame_done_d = 1'b1;
            // New frames take effect only on the wrap, never mid-frame.
            if (!load_ready_q) begin
              shadow_d     = pending_q;
              load_ready_d = 1'b1;
            end
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
    endcase

    // Accept needs an empty slot, so it can never collide with a commit.
    if (load_if.load_valid && load_ready_q) begin
      pending_d    = load_if.load_data;
      load_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: shadow and pending are cleared too, because digit_code must read 0
      // straight out of reset and stale pending data must be discarded.
      state_q        <= ST_BLANK;
      index_q        <= '0;
      shadow_q       <= '0;
      pending_q      <= '0;
      load_ready_q   <= 1'b1;
      segment_out_q  <= '0;
      digit_enable_q <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      load_ready_q   <= load_ready_d;
      segment_out_q  <= segment_out_d;
      digit_enable_q <= digit_enable_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign load_if.load_ready = load_ready_q;
  assign digit_code         = shadow_q[index_q*CODE_W +: CODE_W];
  assign segment_out        = segment_out_q;
  assign digit_enable       = digit_enable_q;
  assign frame_done         = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (4 digits, dwell 4, blank 2) with a display-event scoreboard.
module tb_display_scan_controller;
  import display_scan_controller_pkg::*;

  localparam int ND     = 4;
  localparam int DWELL  = 4;
  localparam int BLANK  = 2;
  localparam int SLOT   = BLANK + DWELL;
  localparam int FRAME  = ND * SLOT;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    logic [ND-1:0]    en;
    logic [SEG_W-1:0] seg;
  } ev_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 scan_en;
  logic [CODE_W-1:0]    digit_code;
  logic [SEG_W-1:0]     segment_in;
  logic [SEG_W-1:0]     segment_out;
  logic [ND-1:0]        digit_enable;
  logic                 frame_done;

  int                   n_tests = 0;
  int                   n_fail  = 0;
  int                   k       = 0;
  logic [CODE_W*ND-1:0] exp_shadow = '0;
  ev_t                  exp_q[$];
  ev_t                  ev;
  logic [ND-1:0]        mon_prev = '0;

  display_scan_controller_if #(.NUM_DIGITS(ND)) lif ();

  display_scan_controller #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .scan_en      (scan_en),
    .load_if      (lif),
    .digit_code   (digit_code),
    .segment_in   (segment_in),
    .segment_out  (segment_out),
    .digit_enable (digit_enable),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: any injective code->pattern map will do.
  function automatic logic [SEG_W-1:0] seg_model(input logic [CODE_W-1:0] c);
    return {c, ~c, c ^ 4'h5, c[2:0]};
  endfunction

  assign segment_in = seg_model(digit_code);

  function automatic bit lit(input logic [CODE_W*ND-1:0] v, input int i);
    return !LZB || (i == 0) || ((v >> (CODE_W * i)) != '0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Expected shape with scan_en high: 2 dark cycles then 4 lit per digit.
  task automatic check_scan();
    logic [ND-1:0] exp_en;
    int d;
    exp_en = '0;
    d = (k / SLOT) % ND;
    if ((k % SLOT) >= BLANK && lit(exp_shadow, d)) exp_en = ND'(1) << d;
    check($sformatf("enable_k%0d", k), 32'(digit_enable), 32'(exp_en));
    check($sformatf("frame_done_k%0d", k), 32'(frame_done), 32'((k > 0) && (k % FRAME == 0)));
  endtask

  task automatic run_to(input int k_end);
    while (k < k_end) begin
      tick();
      check_scan();
    end
  endtask

  task automatic push_frame(input logic [CODE_W*ND-1:0] v);
    for (int i = 0; i < ND; i++) begin
      if (lit(v, i)) exp_q.push_back('{en: ND'(1) << i, seg: seg_model(v[i*CODE_W +: CODE_W])});
    end
  endtask

  // Each time a digit lights up, the next scoreboard entry must match it.
  always @(negedge clk) begin
    if (reset !== 1'b1 && digit_enable !== '0 && mon_prev === '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_show", 32'(digit_enable), 32'h0);
      end else begin
        ev = exp_q.pop_front();
        check("show_enable", 32'(digit_enable), 32'(ev.en));
        check("show_segment", 32'(segment_out), 32'(ev.seg));
      end
    end
    mon_prev = digit_enable;
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_enable"},     32'(digit_enable), 32'h0);
    check({tag, "_segment"},    32'(segment_out),  32'h0);
    check({tag, "_ready"},      32'(lif.load_ready), 32'h1);
    check({tag, "_code"},       32'(digit_code),   32'h0);
    check({tag, "_frame_done"}, 32'(frame_done),   32'h0);
  endtask

  initial begin
    reset          = 1'b1;
    scan_en        = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    repeat (3) tick();
    check_reset_state("reset");

    // Scan from reset with blank shadow.
    reset      = 1'b0;
    scan_en    = 1'b1;
    k          = 0;
    exp_shadow = '0;
    push_frame(exp_shadow);
    run_to(FRAME);

    // Mid-frame load, then a second load offered while pending is full.
    push_frame(exp_shadow);
    run_to(30);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h4321;
    run_to(31);
    check("load_accept_ready", 32'(lif.load_ready), 32'h0);
    lif.load_valid = 1'b0;
    run_to(36);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h8765;
    run_to(40);
    check("code_held_mid_frame", 32'(digit_code), 32'h0);
    check("stall_ready", 32'(lif.load_ready), 32'h0);
    run_to(2 * FRAME);
    exp_shadow = 16'h4321;
    push_frame(exp_shadow);
    check("commit_ready", 32'(lif.load_ready), 32'h1);
    check("commit_code", 32'(digit_code), 32'h1);
    run_to(2 * FRAME + 1);
    check("second_accept_ready", 32'(lif.load_ready), 32'h0);
    lif.load_valid = 1'b0;
    run_to(3 * FRAME);
    exp_shadow = 16'h8765;
    push_frame(exp_shadow);
    check("second_commit_ready", 32'(lif.load_ready), 32'h1);

    // Drop scan_en during digit 1's last dwell cycle.
    run_to(83);
    scan_en = 1'b0;
    run_to(84);
    repeat (8) begin
      tick();
      check("paused_enable", 32'(digit_enable), 32'h0);
      check("paused_code", 32'(digit_code), 32'h7);
    end
    k       = 84;
    scan_en = 1'b1;
    run_to(4 * FRAME);
    push_frame(exp_shadow);

    // Load then reset in digit 2's dwell: everything clears, pending discarded.
    run_to(100);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'hABCD;
    run_to(101);
    check("pre_reset_ready", 32'(lif.load_ready), 32'h0);
    lif.load_valid = 1'b0;
    run_to(111);
    reset = 1'b1;
    tick();
    check_reset_state("midreset");
    check("midreset_queue", 32'(exp_q.size()), 32'h1);
    exp_q.delete();
    reset      = 1'b0;
    k          = 0;
    exp_shadow = '0;
    push_frame(exp_shadow);
    run_to(FRAME);
    check("post_reset_ready", 32'(lif.load_ready), 32'h1);
    check("post_reset_code", 32'(digit_code), 32'h0);

`ifdef LEADING_ZERO_BLANK_EN
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h0050;
    push_frame(exp_shadow);
    run_to(FRAME + 1);
    lif.load_valid = 1'b0;
    run_to(2 * FRAME);
    exp_shadow = 16'h0050;
    push_frame(exp_shadow);
    run_to(3 * FRAME);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h0000;
    push_frame(exp_shadow);
    run_to(3 * FRAME + 1);
    lif.load_valid = 1'b0;
    run_to(4 * FRAME);
    exp_shadow = 16'h0000;
    push_frame(exp_shadow);
    run_to(5 * FRAME);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
